// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified SRAM arbiter: FSM encoding, fetch byte-select fill
// and the watchdog counter width helper.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_D_WAIT = 2'd1;
  localparam logic [1:0] ST_I_WAIT = 2'd2;

  // Replicated to DATA_W/8 bits wherever a full-word select is needed.
  localparam logic SEL_ALL = 1'b1;

  function automatic int to_cnt_w(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// SRAM-side bus of the arbiter: registered command out, read data and ack in,
// plus the watchdog error pulse.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              req;
  logic              we;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;

  modport master (output req, we, sel, addr, wdata, err, input rdata, ack);
  modport slave  (input req, we, sel, addr, wdata, err, output rdata, ack);
endinterface

// File: rtl/mem_arb_watchdog.sv
// Bus-cycle watchdog: reloads on every issue and flags expiry once the request has been
// outstanding for TIMEOUT_CYCLES cycles without an ack. Built only with MEM_ARB_TIMEOUT_EN.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  input  logic ack,
  output logic expire
);
  localparam int CW = to_cnt_w(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  // cnt equals the number of cycles the request has been visible on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt <= '0;
    else if (start)                  cnt <= CW'(1);
    else if (busy && !ack && !expire) cnt <= cnt + 1'b1;
  end

  assign expire = busy & (cnt == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port SRAM bus, data first, and holds
// the pipeline stalled until every access requested this cycle has completed.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ce_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic [DATA_W-1:0]   i_inst_o,
  input  logic                d_ce_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  input  logic                flush_i,
  output logic                stallreq_o,
  mem_arbiter_if.master       bus
);
  localparam int SEL_W = DATA_W / 8;

  logic [1:0]        state;
  logic              d_done, i_done, drop;
  logic              d_pend, i_pend, issue_d, issue_i;
  logic              expire, fin, drop_now;
  logic [DATA_W-1:0] rdata_in;

  assign d_pend     = d_ce_i & ~d_done;
  assign i_pend     = i_ce_i & ~i_done;
  assign stallreq_o = d_pend | i_pend | drop;

  // I_WAIT with req low is the issue slot for a fetch that queued behind a data access.
  assign issue_d  = (state == ST_IDLE) & d_pend;
  assign issue_i  = ((state == ST_IDLE) & ~d_pend & i_pend) |
                    ((state == ST_I_WAIT) & ~bus.req & i_pend);
  assign fin      = bus.req & (bus.ack | expire);
  assign rdata_in = bus.ack ? bus.rdata : '0;
  assign drop_now = drop | flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.sel   <= '0;
      bus.addr  <= '0;
      bus.wdata <= '0;
      i_inst_o  <= '0;
      d_rdata_o <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (issue_d) begin
            bus.req   <= 1'b1;
            bus.we    <= d_we_i;
            bus.sel   <= d_sel_i;
            bus.addr  <= d_addr_i;
            bus.wdata <= d_wdata_i;
            state     <= ST_D_WAIT;
          end else if (issue_i) begin
            bus.req  <= 1'b1;
            bus.we   <= 1'b0;
            bus.sel  <= {SEL_W{SEL_ALL}};
            bus.addr <= i_addr_i;
            state    <= ST_I_WAIT;
          end
        end
        ST_D_WAIT: begin
          if (fin) begin
            bus.req <= 1'b0;
            if (!bus.we) d_rdata_o <= rdata_in;
            state <= i_pend ? ST_I_WAIT : ST_IDLE;
          end
        end
        ST_I_WAIT: begin
          if (issue_i) begin
            bus.req  <= 1'b1;
            bus.we   <= 1'b0;
            bus.sel  <= {SEL_W{SEL_ALL}};
            bus.addr <= i_addr_i;
          end else if (fin) begin
            bus.req <= 1'b0;
            if (!drop_now) i_inst_o <= rdata_in;
            state <= ST_IDLE;
          end else if (!bus.req) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Done flags live for one pipeline step; a dropped fetch never counts as done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_done <= 1'b0;
      i_done <= 1'b0;
      drop   <= 1'b0;
    end else begin
      if (!stallreq_o || flush_i) begin
        d_done <= 1'b0;
        i_done <= 1'b0;
      end else begin
        if (fin && state == ST_D_WAIT)          d_done <= 1'b1;
        if (fin && state == ST_I_WAIT && !drop) i_done <= 1'b1;
      end
      if (fin && state == ST_I_WAIT)                      drop <= 1'b0;
      else if (flush_i && state == ST_I_WAIT && bus.req) drop <= 1'b1;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (issue_d | issue_i),
    .busy   (bus.req),
    .ack    (bus.ack),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.err <= 1'b0;
    else      bus.err <= expire & ~bus.ack;
  end
`else
  assign expire  = 1'b0;
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: SRAM responder with scripted wait states, vector table,
// hand sequences for flush/timeout/reset, and randomized steps against a step-level model.
module tb_mem_arbiter;
  logic        clk, rst;
  logic        i_ce, d_ce, d_we, flush, stallreq;
  logic [31:0] i_addr, i_inst, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_sel;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_ce_i(i_ce), .i_addr_i(i_addr), .i_inst_o(i_inst),
    .d_ce_i(d_ce), .d_we_i(d_we), .d_sel_i(d_sel), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_rdata_o(d_rdata),
    .flush_i(flush), .stallreq_o(stallreq), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // SRAM contents (slave) and the model's own copy, same power-up pattern.
  logic [31:0] sram [logic [31:0]];
  logic [31:0] refm [logic [31:0]];

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram.exists(a) ? sram[a] : def_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : def_word(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] sel,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // SRAM responder: wait_q gives, per request, how many extra req cycles precede ack
  // (0 = ack in the first cycle req is seen).
  int          wait_q[$];
  logic [68:0] log_q[$];

  initial begin
    logic        in_req;
    int          age, cur_wait;
    logic [68:0] cur_cmd;
    in_req = 1'b0; age = 0; cur_wait = 0; cur_cmd = '0;
    bus.ack = 1'b0; bus.rdata = '0;
    forever begin
      @(posedge clk); #2;
      bus.ack = 1'b0;
      if (!bus.req) in_req = 1'b0;
      else begin
        if (!in_req) begin
          in_req   = 1'b1;
          age      = 0;
          cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
          cur_cmd  = {bus.we, bus.sel, bus.addr, bus.wdata};
          log_q.push_back(cur_cmd);
        end
        if (age == cur_wait) begin
          chk("cmd_stable", {59'd0, bus.we, bus.sel, bus.addr, bus.wdata}, {59'd0, cur_cmd});
          bus.ack = 1'b1;
          if (bus.we) begin
            sram[bus.addr] = merge(sram_rd(bus.addr), bus.sel, bus.wdata);
            bus.rdata = $urandom;
          end else bus.rdata = sram_rd(bus.addr);
          in_req = 1'b0;
        end else age++;
      end
    end
  end

  // One pipeline step: hold requests until stallreq drops, return stalled cycle count.
  task automatic step(input logic dce, input logic dwe, input logic [3:0] dsel,
                      input logic [31:0] daddr, input logic [31:0] dwd, input logic ice,
                      input logic [31:0] iaddr, input int wd, input int wi, output int ncyc);
    bit fin;
    wait_q.delete();
    if (dce) wait_q.push_back(wd);
    if (ice) wait_q.push_back(wi);
    d_ce = dce; d_we = dwe; d_sel = dsel; d_addr = daddr; d_wdata = dwd;
    i_ce = ice; i_addr = iaddr; flush = 1'b0;
    ncyc = 0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (!stallreq) fin = 1'b1;
      else begin
        ncyc++;
        if (ncyc > 60) fin = 1'b1;
      end
    end
    @(posedge clk); #1;
    d_ce = 1'b0; i_ce = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        dce, dwe;
    logic [3:0]  dsel;
    logic [31:0] daddr, dwd;
    logic        ice;
    logic [31:0] iaddr;
    int          wd, wi, stall;
    logic [31:0] exp_d, exp_i;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] exp_d, exp_i;

  initial begin
    int n;
    rst = 1'b0; i_ce = 0; d_ce = 0; d_we = 0; d_sel = '0; d_addr = '0; d_wdata = '0;
    i_addr = '0; flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", bus.req, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_cmd", {bus.sel, bus.addr, bus.wdata}, 0);
    chk("rst_outs", {i_inst, d_rdata}, 0);
    chk("rst_stall", stallreq, 0);
    @(posedge clk); #1 rst = 1'b1;

    foreach (sram[a]) sram.delete(a);
    sram[32'h100] = 32'h24010005;  refm[32'h100] = 32'h24010005;
    sram[32'h104] = 32'h3C011234;  refm[32'h104] = 32'h3C011234;
    sram[32'h2000] = 32'h11223344; refm[32'h2000] = 32'h11223344;
    sram[32'h2004] = 32'hCAFEF00D; refm[32'h2004] = 32'hCAFEF00D;

    //          name       dce dwe sel    daddr        dwdata        ice iaddr     wd wi st exp_d         exp_i
    vecs[0] = '{"fetch",     0, 0, 4'h0, 32'h0,     32'h0,        1, 32'h100, 0, 0, 2, 32'h0,        32'h24010005};
    vecs[1] = '{"store",     1, 1, 4'h3, 32'h2000,  32'hDEADBEEF, 0, 32'h0,   0, 0, 2, 32'h0,        32'h24010005};
    vecs[2] = '{"ld_fetch",  1, 0, 4'hF, 32'h2000,  32'h0,        1, 32'h104, 0, 0, 4, 32'h1122BEEF, 32'h3C011234};
    vecs[3] = '{"ld_wait2",  1, 0, 4'hF, 32'h2004,  32'h0,        0, 32'h0,   2, 0, 4, 32'hCAFEF00D, 32'h3C011234};
    vecs[4] = '{"idle",      0, 0, 4'h0, 32'h0,     32'h0,        0, 32'h0,   0, 0, 0, 32'hCAFEF00D, 32'h3C011234};
    vecs[5] = '{"both_wait", 1, 0, 4'hF, 32'h2000,  32'h0,        1, 32'h100, 1, 2, 7, 32'h1122BEEF, 32'h24010005};
    vecs[6] = '{"st_fetch",  1, 1, 4'hC, 32'h2004,  32'h0BADF00D, 1, 32'h104, 1, 0, 5, 32'h1122BEEF, 32'h3C011234};

    for (int v = 0; v < 7; v++) begin
      log_q.delete();
      step(vecs[v].dce, vecs[v].dwe, vecs[v].dsel, vecs[v].daddr, vecs[v].dwd,
           vecs[v].ice, vecs[v].iaddr, vecs[v].wd, vecs[v].wi, n);
      if (vecs[v].dce && vecs[v].dwe) refm[vecs[v].daddr] =
        merge(ref_rd(vecs[v].daddr), vecs[v].dsel, vecs[v].dwd);
      chk({vecs[v].name, "_stall"}, n, vecs[v].stall);
      chk({vecs[v].name, "_drdata"}, d_rdata, vecs[v].exp_d);
      chk({vecs[v].name, "_inst"}, i_inst, vecs[v].exp_i);
      chk({vecs[v].name, "_nbus"}, log_q.size(), int'(vecs[v].dce) + int'(vecs[v].ice));
      if (vecs[v].dce && log_q.size() > 0)
        chk({vecs[v].name, "_bus0"}, log_q[0],
            {vecs[v].dwe, vecs[v].dsel, vecs[v].daddr, vecs[v].dwe ? vecs[v].dwd : log_q[0][31:0]});
      if (vecs[v].dce && vecs[v].ice && log_q.size() > 1)
        chk({vecs[v].name, "_bus1"}, log_q[1][68:32], {1'b0, 4'hF, vecs[v].iaddr});
    end
    exp_d = vecs[6].exp_d;
    exp_i = vecs[6].exp_i;

    // Flush while a fetch is on the bus: cycle completes, result discarded.
    wait_q.delete(); wait_q.push_back(3);
    i_ce = 1'b1; i_addr = 32'h108;
    @(posedge clk); #1;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk); chk("flush_stall_c2", stallreq, 1);
    @(posedge clk); #1 flush = 1'b0; i_ce = 1'b0;
    @(negedge clk); chk("flush_stall_c3", stallreq, 1); chk("flush_req_held", bus.req, 1);
    @(negedge clk); chk("flush_stall_ack", stallreq, 1); chk("flush_ack", bus.ack, 1);
    @(negedge clk); chk("flush_release", stallreq, 0); chk("flush_inst_kept", i_inst, exp_i);
    @(posedge clk); #1;
    step(0, 0, 4'h0, 0, 0, 1, 32'h108, 0, 0, n);
    exp_i = ref_rd(32'h108);
    chk("refetch_stall", n, 2);
    chk("refetch_inst", i_inst, exp_i);

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int err_at, err_cnt;
      bit fin;
      wait_q.delete(); wait_q.push_back(1000);
      d_ce = 1'b1; d_we = 1'b0; d_addr = 32'h2004;
      n = 0; err_at = -1; err_cnt = 0; fin = 1'b0;
      while (!fin) begin
        @(negedge clk);
        if (bus.err) begin err_cnt++; err_at = n; end
        if (!stallreq) fin = 1'b1;
        else begin n++; if (n > 40) fin = 1'b1; end
      end
      @(posedge clk); #1 d_ce = 1'b0;
      @(negedge clk);
      if (bus.err) err_cnt++;
      exp_d = '0;
      chk("to_stall", n, 9);
      chk("to_err_at", err_at, 9);
      chk("to_err_pulses", err_cnt, 1);
      chk("to_drdata", d_rdata, exp_d);
      chk("to_req_drop", bus.req, 0);
    end
`else
    chk("err_tied_off", bus.err, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      logic        dce, dwe, ice;
      logic [3:0]  dsel;
      logic [31:0] da, dw, ia;
      int          wd, wi, expn;
      dce = 1'($urandom); dwe = 1'($urandom); ice = 1'($urandom);
      dsel = 4'($urandom_range(1, 15));
      da = 32'h2000 + 32'(4 * $urandom_range(0, 7));
      ia = 32'h100 + 32'(4 * $urandom_range(0, 7));
      dw = $urandom;
      wd = $urandom_range(0, 3); wi = $urandom_range(0, 3);
      expn = (dce ? wd + 2 : 0) + (ice ? wi + 2 : 0);
      step(dce, dwe, dsel, da, dw, ice, ia, wd, wi, n);
      if (dce && !dwe) exp_d = ref_rd(da);
      if (dce && dwe)  refm[da] = merge(ref_rd(da), dsel, dw);
      if (ice)         exp_i = ref_rd(ia);
      chk("rnd_stall", n, expn);
      chk("rnd_drdata", d_rdata, exp_d);
      chk("rnd_inst", i_inst, exp_i);
    end

    // Reset lands in the middle of a load's bus cycle.
    wait_q.delete(); wait_q.push_back(5);
    d_ce = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("pre_rst_req", bus.req, 1);
    rst = 1'b0; d_ce = 1'b0;
    #1;
    chk("midrst_req", bus.req, 0);
    chk("midrst_cmd", {bus.we, bus.sel, bus.addr, bus.wdata}, 0);
    chk("midrst_outs", {i_inst, d_rdata}, 0);
    chk("midrst_stall", stallreq, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    step(0, 0, 4'h0, 0, 0, 1, 32'h100, 0, 0, n);
    chk("post_rst_stall", n, 2);
    chk("post_rst_inst", i_inst, 32'h24010005);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
